// File: rtl/rf_hazard_pkg.sv
// Shared types and helpers for the register-file hazard controller.
// Entries store the destination register at a fixed width (HZ_RD_W) so the
// package needs no parameter; the top zero-extends REG_AW-wide addresses into it.
package rf_hazard_pkg;

  // Widest register address the entry struct can hold (top's REG_AW must not exceed it).
  localparam int HZ_RD_W = 8;

  // Register x0 is hard-wired to zero and never creates a dependency.
  localparam logic [HZ_RD_W-1:0] REG_ZERO = '0;

  // Operand source selects for the rD1/rD2 operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic               valid;
    logic [HZ_RD_W-1:0] rd;
    logic               we;
    logic               is_load;
  } hz_entry_t;

  // Youngest matching producer wins; callers mask out EX loads before calling.
  function automatic fwd_sel_t pick_fwd(input logic ex_hit, input logic mem_hit,
                                        input logic wb_hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_hazard_ctrl_hz_match.sv
// Compares one pipeline entry against one ID source operand.
// A hit means the entry will write the register this operand actually reads.
module hz_match
  import rf_hazard_pkg::*;
(
  input  hz_entry_t          entry,
  input  logic [HZ_RD_W-1:0] rs,
  input  logic               rs_used,
  input  logic               id_valid,
  output logic               hit
);

  // The load flag matters only to the caller; sink it here.
  logic unused_is_load;
  assign unused_is_load = entry.is_load;

  // Valid writer of a non-zero register that matches a used source of a valid ID instruction.
  always_comb begin
    hit = entry.valid & entry.we & (entry.rd == rs) & (entry.rd != REG_ZERO)
          & rs_used & id_valid;
  end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// Scoreboard and hazard controller for the decode stage of the 5-stage pipeline.
// Tracks the destination of the instructions in EX, MEM and WB and produces the
// ID stall and the rD1/rD2 forwarding selects.
// Build option: RF_HAZARD_FWD_EN enables forwarding (only load-use stalls);
// without it the selects stay at the regfile and any pending writer stalls ID.
module rf_hazard_ctrl
  import rf_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              mem_wait,
  output logic              stall,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  hz_entry_t          ex_q, ex_d;
  hz_entry_t          mem_q, mem_d;
  hz_entry_t          wb_q, wb_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  hz_entry_t          id_entry;
  logic [HZ_RD_W-1:0] rs1_ext, rs2_ext;

  logic               ex_hit1, ex_hit2;
  logic               mem_hit1, mem_hit2;
  logic               wb_hit1, wb_hit2;

  logic               stall_c;
  fwd_sel_t           rs1_sel, rs2_sel;

  // Widen ID addresses into entry format and build the entry ID would push into EX.
  always_comb begin
    rs1_ext              = '0;
    rs2_ext              = '0;
    id_entry             = '0;
    rs1_ext[REG_AW-1:0]  = id_rs1;
    rs2_ext[REG_AW-1:0]  = id_rs2;
    id_entry.valid       = id_valid;
    id_entry.rd[REG_AW-1:0] = id_rd;
    id_entry.we          = id_rd_we;
    id_entry.is_load     = id_is_load;
  end

  hz_match u_ex_rs1  (.entry(ex_q),  .rs(rs1_ext), .rs_used(id_rs1_used), .id_valid(id_valid), .hit(ex_hit1));
  hz_match u_ex_rs2  (.entry(ex_q),  .rs(rs2_ext), .rs_used(id_rs2_used), .id_valid(id_valid), .hit(ex_hit2));
  hz_match u_mem_rs1 (.entry(mem_q), .rs(rs1_ext), .rs_used(id_rs1_used), .id_valid(id_valid), .hit(mem_hit1));
  hz_match u_mem_rs2 (.entry(mem_q), .rs(rs2_ext), .rs_used(id_rs2_used), .id_valid(id_valid), .hit(mem_hit2));
  hz_match u_wb_rs1  (.entry(wb_q),  .rs(rs1_ext), .rs_used(id_rs1_used), .id_valid(id_valid), .hit(wb_hit1));
  hz_match u_wb_rs2  (.entry(wb_q),  .rs(rs2_ext), .rs_used(id_rs2_used), .id_valid(id_valid), .hit(wb_hit2));

  // Stall and operand selects, combinational from the ID inputs and the held entries.
  always_comb begin
    stall_c = 1'b0;
    rs1_sel = FWD_RF;
    rs2_sel = FWD_RF;
`ifdef RF_HAZARD_FWD_EN
    // Load data only exists after MEM, so an EX load must stall one cycle;
    // while stalled the select value is ignored by the EX bubble.
    stall_c = ex_q.is_load & (ex_hit1 | ex_hit2);
    rs1_sel = pick_fwd(ex_hit1 & ~ex_q.is_load, mem_hit1, wb_hit1);
    rs2_sel = pick_fwd(ex_hit2 & ~ex_q.is_load, mem_hit2, wb_hit2);
`else
    // No bypass paths: wait until every pending writer has left WB.
    stall_c = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2 | wb_hit1 | wb_hit2;
`endif
  end

  // Entry advance and saturating stall counter; everything freezes while memory is busy.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_wait) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (stall_c || flush) begin
        ex_d = '0;
      end else begin
        ex_d = id_entry;
      end
      if (stall_c && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall       = stall_c;
  assign fwd_rs1_sel = rs1_sel;
  assign fwd_rs2_sel = rs2_sel;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Directed self-checking bench for rf_hazard_ctrl.
// Expected values follow the build: RF_HAZARD_FWD_EN selects forwarding expectations.
module tb_rf_hazard_ctrl;

`ifdef RF_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        flush;
  logic        mem_wait;
  logic        stall;
  logic [1:0]  fwd_rs1_sel;
  logic [1:0]  fwd_rs2_sel;
  logic [31:0] stall_cnt;

  int n_checks;
  int n_fail;

  rf_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd      (id_rd),
    .id_rd_we   (id_rd_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .mem_wait   (mem_wait),
    .stall      (stall),
    .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled around the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_rd_we    = we;
    id_is_load  = ld;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    mem_wait = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    mem_wait = 1'b0;
    idle();
    @(negedge clk);
    // A dependent-looking ID instruction must not see any entry right after reset.
    drive_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs1_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_sel1: got %b want 00", fwd_rs1_sel); end
    n_checks++;
    if (fwd_rs2_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_sel2: got %b want 00", fwd_rs2_sel); end
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_ex_forward();
    logic       exp_stall;
    logic [1:0] exp_sel;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_sel   = FWD ? 2'b01 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL exfwd_stall: got %0b want %0b", stall, exp_stall); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL exfwd_sel1: got %b want %b", fwd_rs1_sel, exp_sel); end
    n_checks++;
    if (fwd_rs2_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL exfwd_sel2: got %b want %b", fwd_rs2_sel, exp_sel); end
    idle();
  endtask

  task automatic test_load_use();
    logic       exp_stall;
    logic [1:0] exp_sel;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_sel   = FWD ? 2'b10 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lduse_stall: got %0b want 1", stall); end
    step();
    #1;
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL lduse_stall_next: got %0b want %0b", stall, exp_stall); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL lduse_sel1_next: got %b want %b", fwd_rs1_sel, exp_sel); end
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL lduse_cnt: got %0d want 1", stall_cnt); end
    idle();
  endtask

  task automatic test_mem_wb_priority();
    logic       exp_stall;
    logic [1:0] exp_mem;
    logic [1:0] exp_wb;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_mem   = FWD ? 2'b10 : 2'b00;
    exp_wb    = FWD ? 2'b11 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0);
    step();
    idle();
    step();
    // Now MEM and WB both write x9.
    drive_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (fwd_rs1_sel !== exp_mem) begin n_fail++; $display("[TB] FAIL memwb_sel1: got %b want %b", fwd_rs1_sel, exp_mem); end
    n_checks++;
    if (fwd_rs2_sel !== exp_mem) begin n_fail++; $display("[TB] FAIL memwb_sel2: got %b want %b", fwd_rs2_sel, exp_mem); end
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL memwb_stall: got %0b want %0b", stall, exp_stall); end
    idle();
    step();
    // Only WB still writes x9.
    drive_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (fwd_rs1_sel !== exp_wb) begin n_fail++; $display("[TB] FAIL wbonly_sel1: got %b want %b", fwd_rs1_sel, exp_wb); end
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL wbonly_stall: got %0b want %0b", stall, exp_stall); end
    idle();
  endtask

  task automatic test_x0_and_unused();
    logic       exp_stall;
    logic [1:0] exp_sel1;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_sel1  = FWD ? 2'b01 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_stall: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs1_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL x0_sel1: got %b want 00", fwd_rs1_sel); end
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    // rs1 used and matching, rs2 matching but unused.
    drive_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd11, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (fwd_rs2_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL unused_sel2: got %b want 00", fwd_rs2_sel); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel1) begin n_fail++; $display("[TB] FAIL used_sel1: got %b want %b", fwd_rs1_sel, exp_sel1); end
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL used_stall: got %0b want %0b", stall, exp_stall); end
    drive_id(1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 5'd11, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL both_unused_stall: got %0b want 0", stall); end
    drive_id(1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL id_invalid_stall: got %0b want 0", stall); end
    idle();
  endtask

  task automatic test_flush();
    logic [1:0] exp_sel;
    exp_sel = FWD ? 2'b10 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_stall_comb: got %0b want 1", stall); end
    step();
    flush = 1'b0;
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL flush_cnt: got %0d want 0", stall_cnt); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL flush_sel1: got %b want %b", fwd_rs1_sel, exp_sel); end
    // A flushed producer never reaches EX.
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL killed_stall: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs1_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL killed_sel1: got %b want 00", fwd_rs1_sel); end
    idle();
  endtask

  task automatic test_mem_wait();
    logic       exp_stall;
    logic [1:0] exp_sel;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_sel   = FWD ? 2'b10 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_stall_pre: got %0b want 1", stall); end
    mem_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL wait_stall_%0d: got %0b want 1", c, stall); end
      n_checks++;
      if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL wait_cnt_%0d: got %0d want 0", c, stall_cnt); end
    end
    mem_wait = 1'b0;
    step();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL wait_cnt_after: got %0d want 1", stall_cnt); end
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL wait_stall_after: got %0b want %0b", stall, exp_stall); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL wait_sel1_after: got %b want %b", fwd_rs1_sel, exp_sel); end
    idle();
  endtask

  task automatic test_dep_chain();
    logic [1:0] fwd_seq [4];
    logic       exp_stall;
    logic [1:0] exp_sel;
    logic [31:0] exp_cnt;
    fwd_seq[0] = 2'b01;
    fwd_seq[1] = 2'b10;
    fwd_seq[2] = 2'b11;
    fwd_seq[3] = 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    // ID keeps reading x3 while the addi drains through EX, MEM and WB.
    drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      exp_stall = (FWD || c == 3) ? 1'b0 : 1'b1;
      exp_sel   = FWD ? fwd_seq[c] : 2'b00;
      exp_cnt   = FWD ? 32'd0 : 32'(c);
      #1;
      n_checks++;
      if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL chain_stall_%0d: got %0b want %0b", c, stall, exp_stall); end
      n_checks++;
      if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL chain_sel1_%0d: got %b want %b", c, fwd_rs1_sel, exp_sel); end
      n_checks++;
      if (stall_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL chain_cnt_%0d: got %0d want %0d", c, stall_cnt, exp_cnt); end
      step();
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic       exp_stall;
    logic [1:0] exp_sel;
    exp_stall = FWD ? 1'b0 : 1'b1;
    exp_sel   = FWD ? 2'b10 : 2'b00;
    do_reset();
    drive_id(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    #1;
    n_checks++;
    if (stall !== exp_stall) begin n_fail++; $display("[TB] FAIL arst_pre_stall: got %0b want %0b", stall, exp_stall); end
    n_checks++;
    if (fwd_rs1_sel !== exp_sel) begin n_fail++; $display("[TB] FAIL arst_pre_sel1: got %b want %b", fwd_rs1_sel, exp_sel); end
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL arst_pre_cnt: got %0d want 1", stall_cnt); end
    // Reset between clock edges must clear everything at once.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_stall: got %0b want 0", stall); end
    n_checks++;
    if (fwd_rs1_sel !== 2'b00) begin n_fail++; $display("[TB] FAIL arst_sel1: got %b want 00", fwd_rs1_sel); end
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL arst_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    $display("[TB] rf_hazard_ctrl bench, forwarding build = %0b", FWD);
    test_reset();
    test_ex_forward();
    test_load_use();
    test_mem_wb_priority();
    test_x0_and_unused();
    test_flush();
    test_mem_wait();
    test_dep_chain();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
